// File: rtl/backprop_step1_ctrl_if.sv
// rtl/backprop_step1_ctrl_if.sv - weight RAM port and datapath operand bus of the weight-update sequencer
interface backprop_step1_ctrl_if #(
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] w_addr;
  logic              w_rd_en;
  logic [31:0]       w_rdata;
  logic              w_we;
  logic [31:0]       w_wdata;
  logic [31:0]       dp_target;
  logic [31:0]       dp_output_sigmoid;
  logic [31:0]       dp_hidden_sigmoid;
  logic [31:0]       dp_w_initial;
  logic [31:0]       dp_w_update;

  modport master (
    output w_addr, w_rd_en, w_we, w_wdata,
    output dp_target, dp_output_sigmoid, dp_hidden_sigmoid, dp_w_initial,
    input  w_rdata, dp_w_update
  );

  modport slave (
    input  w_addr, w_rd_en, w_we, w_wdata,
    input  dp_target, dp_output_sigmoid, dp_hidden_sigmoid, dp_w_initial,
    output w_rdata, dp_w_update
  );
endinterface

// File: rtl/backprop_step1_ctrl.sv
// rtl/backprop_step1_ctrl.sv - sequencer walking every output-layer weight through read/load/settle/write
// Optional BP_NAN_GUARD_EN: keep the old weight and raise sticky err when the datapath returns Inf/NaN.
module backprop_step1_ctrl #(
  parameter int N_HIDDEN = 2,
  parameter int N_OUT    = 2,
  parameter int ADDR_W   = 2,
  parameter int DP_LAT   = 1,
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int HW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [OW-1:0]          out_idx,
  output logic [HW-1:0]          hid_idx,
  input  logic [31:0]            target_in,
  input  logic [31:0]            out_sig_in,
  input  logic [31:0]            hid_sig_in,
  backprop_step1_ctrl_if.master  bus,
  output logic                   err
);

  localparam int CW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);
  localparam logic [HW-1:0] HID_LAST = HW'(N_HIDDEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [OW-1:0] out_q;
  logic [HW-1:0] hid_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   dp_target_q;
  logic [31:0]   dp_out_sig_q;
  logic [31:0]   dp_hid_sig_q;
  logic [31:0]   dp_w_init_q;
  logic [31:0]   wdata_sel;
  logic          rd_en;
  logic          we;
  logic [31:0]   wdata;
  logic          last_w;

  assign last_w = (out_q == OUT_LAST) && (hid_q == HID_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // start is only honoured from IDLE; DONE always falls back to IDLE first
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_READ;
      S_READ:  state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_w ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    rd_en = 1'b0;
    we    = 1'b0;
    wdata = 32'h0;
    case (state)
      S_READ: begin
        busy  = 1'b1;
        rd_en = 1'b1;
      end
      S_LOAD, S_WAIT: begin
        busy = 1'b1;
      end
      S_WRITE: begin
        busy  = 1'b1;
        we    = 1'b1;
        wdata = wdata_sel;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Operands are captured once per weight so the datapath sees stable inputs through WAIT and WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      hid_q        <= '0;
      wait_cnt     <= '0;
      dp_target_q  <= 32'h0;
      dp_out_sig_q <= 32'h0;
      dp_hid_sig_q <= 32'h0;
      dp_w_init_q  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            out_q <= '0;
            hid_q <= '0;
          end
        end
        S_LOAD: begin
          dp_w_init_q  <= bus.w_rdata;
          dp_target_q  <= target_in;
          dp_out_sig_q <= out_sig_in;
          dp_hid_sig_q <= hid_sig_in;
          wait_cnt     <= CW'(DP_LAT - 1);
        end
        S_WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
        end
        S_WRITE: begin
          if (!last_w) begin
            if (hid_q == HID_LAST) begin
              hid_q <= '0;
              out_q <= out_q + 1'b1;
            end else begin
              hid_q <= hid_q + 1'b1;
            end
          end
        end
        default: begin
          wait_cnt <= wait_cnt;
        end
      endcase
    end
  end

`ifdef BP_NAN_GUARD_EN
  logic dp_bad;
  logic err_q;

  assign dp_bad    = (bus.dp_w_update[30:23] == 8'hFF);
  assign wdata_sel = dp_bad ? dp_w_init_q : bus.dp_w_update;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err_q <= 1'b0;
    end else if (state == S_WRITE && dp_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wdata_sel = bus.dp_w_update;
  assign err       = 1'b0;
`endif

  assign out_idx               = out_q;
  assign hid_idx               = hid_q;
  assign bus.w_addr            = ADDR_W'(int'(out_q) * N_HIDDEN + int'(hid_q));
  assign bus.w_rd_en           = rd_en;
  assign bus.w_we              = we;
  assign bus.w_wdata           = wdata;
  assign bus.dp_target         = dp_target_q;
  assign bus.dp_output_sigmoid = dp_out_sig_q;
  assign bus.dp_hidden_sigmoid = dp_hid_sig_q;
  assign bus.dp_w_initial      = dp_w_init_q;

  a_no_rd_wr_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.w_rd_en && bus.w_we));

  a_load_then_wait: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_LOAD) |=> (state == S_WAIT));

endmodule

// File: tb/tb_backprop_step1_ctrl.sv
// tb/tb_backprop_step1_ctrl.sv - directed self-checking bench for backprop_step1_ctrl (honours BP_NAN_GUARD_EN)
`timescale 1ns/1ps
module tb_backprop_step1_ctrl;
  localparam logic [31:0] TGT  = 32'h3F80_0000;
  localparam logic [31:0] OSIG = 32'h3F00_0000;
  localparam logic [31:0] HSIG = 32'h3F80_0000;
  localparam logic [31:0] HALF = 32'h3F00_0000;
  localparam logic [31:0] NEWW = 32'h3F20_0000;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
`ifdef BP_NAN_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] start_v = 3'b000;
  logic [2:0] busy_v, done_v, err_v;
  logic oi_a, hi_a, oi_b, hi_b, hi_c;
  logic [1:0] oi_c;

  backprop_step1_ctrl_if #(.ADDR_W(2)) ifa ();
  backprop_step1_ctrl_if #(.ADDR_W(2)) ifb ();
  backprop_step1_ctrl_if #(.ADDR_W(2)) ifc ();

  backprop_step1_ctrl #(.N_HIDDEN(2), .N_OUT(2), .ADDR_W(2), .DP_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .out_idx(oi_a), .hid_idx(hi_a), .target_in(TGT), .out_sig_in(OSIG), .hid_sig_in(HSIG),
    .bus(ifa.master), .err(err_v[0]));

  backprop_step1_ctrl #(.N_HIDDEN(2), .N_OUT(2), .ADDR_W(2), .DP_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .out_idx(oi_b), .hid_idx(hi_b), .target_in(TGT), .out_sig_in(OSIG), .hid_sig_in(HSIG),
    .bus(ifb.master), .err(err_v[1]));

  backprop_step1_ctrl #(.N_HIDDEN(1), .N_OUT(3), .ADDR_W(2), .DP_LAT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .out_idx(oi_c), .hid_idx(hi_c), .target_in(TGT), .out_sig_in(OSIG), .hid_sig_in(HSIG),
    .bus(ifc.master), .err(err_v[2]));

  logic [1:0]  addr_v [3];
  logic [31:0] wdata_v [3];
  logic        rd_v [3];
  logic        we_v [3];
  assign addr_v[0] = ifa.w_addr;  assign addr_v[1] = ifb.w_addr;  assign addr_v[2] = ifc.w_addr;
  assign wdata_v[0] = ifa.w_wdata; assign wdata_v[1] = ifb.w_wdata; assign wdata_v[2] = ifc.w_wdata;
  assign rd_v[0] = ifa.w_rd_en;   assign rd_v[1] = ifb.w_rd_en;   assign rd_v[2] = ifc.w_rd_en;
  assign we_v[0] = ifa.w_we;      assign we_v[1] = ifb.w_we;      assign we_v[2] = ifc.w_we;

  // weight RAM models with one-cycle read latency
  logic [31:0] mem [3][4];
  logic [31:0] rdata_r [3];
  logic [2:0]  init_go = 3'b000;
  logic [31:0] init_base [3];
  logic [31:0] init_inc [3];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (init_go[i]) begin
        for (int k = 0; k < 4; k++) mem[i][k] <= init_base[i] + 32'(k) * init_inc[i];
      end else if (we_v[i]) begin
        mem[i][addr_v[i]] <= wdata_v[i];
      end
      if (rd_v[i]) rdata_r[i] <= mem[i][addr_v[i]];
    end
  end
  assign ifa.w_rdata = rdata_r[0];
  assign ifb.w_rdata = rdata_r[1];
  assign ifc.w_rdata = rdata_r[2];

  // datapath stand-in: w + 0.125 for weights in [0.5,1) exponent range, optional forced NaN
  logic [2:0] nan_en = 3'b000;
  logic [1:0] nan_addr = 2'd0;
  assign ifa.dp_w_update = (nan_en[0] && ifa.w_addr == nan_addr) ? QNAN : ifa.dp_w_initial + 32'h0020_0000;
  assign ifb.dp_w_update = (nan_en[1] && ifb.w_addr == nan_addr) ? QNAN : ifb.dp_w_initial + 32'h0020_0000;
  assign ifc.dp_w_update = (nan_en[2] && ifc.w_addr == nan_addr) ? QNAN : ifc.dp_w_initial + 32'h0020_0000;

  int          cyc = 0;
  logic [1:0]  wr_addr [3][128];
  logic [31:0] wr_data [3][128];
  int          wr_cyc [3][128];
  logic [1:0]  wr_oi_c [128];
  logic        wr_hi_c [128];
  int          wr_n [3];
  int          rd_cyc [3][128];
  int          rd_n [3];
  int          done_cyc [3][32];
  int          done_n [3];
  int          overlap [3];
  int          dp_chg = 0;
  logic        rd_d1 = 1'b0, rd_d2 = 1'b0;
  logic [127:0] dp_prev;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (we_v[i] && wr_n[i] < 128) begin
        wr_addr[i][wr_n[i]] <= addr_v[i];
        wr_data[i][wr_n[i]] <= wdata_v[i];
        wr_cyc[i][wr_n[i]]  <= cyc;
        wr_n[i]             <= wr_n[i] + 1;
      end
      if (rd_v[i] && rd_n[i] < 128) begin
        rd_cyc[i][rd_n[i]] <= cyc;
        rd_n[i]            <= rd_n[i] + 1;
      end
      if (done_v[i] && done_n[i] < 32) begin
        done_cyc[i][done_n[i]] <= cyc;
        done_n[i]              <= done_n[i] + 1;
      end
      if (rd_v[i] && we_v[i]) overlap[i] <= overlap[i] + 1;
    end
    if (we_v[2] && wr_n[2] < 128) begin
      wr_oi_c[wr_n[2]] <= oi_c;
      wr_hi_c[wr_n[2]] <= hi_c;
    end
    rd_d1   <= rd_v[1];
    rd_d2   <= rd_d1;
    dp_prev <= {ifb.dp_target, ifb.dp_output_sigmoid, ifb.dp_hidden_sigmoid, ifb.dp_w_initial};
    if (rst_n && !rd_d2 &&
        ({ifb.dp_target, ifb.dp_output_sigmoid, ifb.dp_hidden_sigmoid, ifb.dp_w_initial} != dp_prev))
      dp_chg <= dp_chg + 1;
    cyc <= cyc + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int i);
    start_v[i] = 1'b1;
    tick(1);
    start_v[i] = 1'b0;
  endtask

  task automatic init_mem(input int i, input logic [31:0] base, input logic [31:0] inc);
    init_base[i] = base;
    init_inc[i]  = inc;
    init_go[i]   = 1'b1;
    tick(1);
    init_go[i]   = 1'b0;
  endtask

  task automatic wait_done(input int i, input int mark, input int budget);
    for (int c = 0; c < budget && done_n[i] <= mark; c++) tick(1);
    total++;
    if (done_n[i] <= mark) begin
      bad++;
      $display("FAIL done_timeout[%0d]: got no done within %0d cycles, want done", i, budget);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    total++; if (busy_v !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", busy_v); end
    total++; if (done_v !== 3'b000) begin bad++; $display("FAIL reset_done: got %b want 000", done_v); end
    total++; if (err_v !== 3'b000) begin bad++; $display("FAIL reset_err: got %b want 000", err_v); end
    total++; if ({ifa.w_rd_en, ifa.w_we} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {ifa.w_rd_en, ifa.w_we}); end
    total++; if ({ifa.w_addr, oi_a, hi_a, ifc.w_addr, oi_c} !== 8'h00) begin bad++; $display("FAIL reset_idx: got %h want 00", {ifa.w_addr, oi_a, hi_a, ifc.w_addr, oi_c}); end
    total++; if (ifa.w_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", ifa.w_wdata); end
    total++; if ({ifa.dp_target, ifa.dp_output_sigmoid, ifa.dp_hidden_sigmoid, ifa.dp_w_initial} !== 128'h0) begin
      bad++; $display("FAIL reset_dp: got %h want 0", {ifa.dp_target, ifa.dp_output_sigmoid, ifa.dp_hidden_sigmoid, ifa.dp_w_initial});
    end
    rst_n = 1'b1;
    tick(3);
    total++; if (busy_v !== 3'b000) begin bad++; $display("FAIL idle_busy: got %b want 000", busy_v); end
  endtask

  task automatic test_basic_pass;
    int wm, rm, dm;
    init_mem(0, HALF, 32'h0);
    wm = wr_n[0]; rm = rd_n[0]; dm = done_n[0];
    pulse(0);
    total++; if ({busy_v[0], ifa.w_rd_en, ifa.w_addr} !== 4'b1100) begin bad++; $display("FAIL basic_read_entry: got %b want 1100", {busy_v[0], ifa.w_rd_en, ifa.w_addr}); end
    wait_done(0, dm, 40);
    total++; if ({done_v[0], busy_v[0]} !== 2'b10) begin bad++; $display("FAIL basic_done_state: got %b want 10", {done_v[0], busy_v[0]}); end
    tick(1);
    total++; if (done_v[0] !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", done_v[0]); end
    total++; if (wr_n[0] - wm !== 4) begin bad++; $display("FAIL basic_wr_count: got %0d want 4", wr_n[0] - wm); end
    for (int k = 0; k < 4; k++) begin
      total++; if (wr_addr[0][wm+k] !== 2'(k)) begin bad++; $display("FAIL basic_wr_addr%0d: got %0d want %0d", k, wr_addr[0][wm+k], k); end
      total++; if (wr_data[0][wm+k] !== NEWW) begin bad++; $display("FAIL basic_wr_data%0d: got %h want %h", k, wr_data[0][wm+k], NEWW); end
      total++; if (wr_cyc[0][wm+k] - rd_cyc[0][rm] !== 3 + 4 * k) begin bad++; $display("FAIL basic_wr_time%0d: got %0d want %0d", k, wr_cyc[0][wm+k] - rd_cyc[0][rm], 3 + 4 * k); end
    end
    total++; if (done_cyc[0][dm] - rd_cyc[0][rm] !== 16) begin bad++; $display("FAIL basic_pass_len: got %0d want 16", done_cyc[0][dm] - rd_cyc[0][rm]); end
    total++; if (err_v[0] !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err_v[0]); end
  endtask

  task automatic test_start_ignore;
    int wm, rm, dm;
    init_mem(0, HALF, 32'h0);
    wm = wr_n[0]; rm = rd_n[0]; dm = done_n[0];
    start_v[0] = 1'b1;
    tick(3);
    start_v[0] = 1'b0;
    tick(4);
    pulse(0);
    wait_done(0, dm, 40);
    start_v[0] = 1'b1;
    tick(1);
    start_v[0] = 1'b0;
    tick(6);
    total++; if (wr_n[0] - wm !== 4) begin bad++; $display("FAIL ignore_wr_count: got %0d want 4", wr_n[0] - wm); end
    total++; if (rd_n[0] - rm !== 4) begin bad++; $display("FAIL ignore_rd_count: got %0d want 4", rd_n[0] - rm); end
    total++; if (done_n[0] - dm !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", done_n[0] - dm); end
    total++; if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL ignore_busy: got %b want 0", busy_v[0]); end
  endtask

  task automatic test_dp_lat3;
    int wm, rm, dm, cm;
    init_mem(1, 32'h3E00_0000, 32'h0001_0000);
    wm = wr_n[1]; rm = rd_n[1]; dm = done_n[1]; cm = dp_chg;
    pulse(1);
    tick(2);
    total++; if (ifb.dp_target !== TGT) begin bad++; $display("FAIL lat3_dp_target: got %h want %h", ifb.dp_target, TGT); end
    total++; if (ifb.dp_output_sigmoid !== OSIG) begin bad++; $display("FAIL lat3_dp_osig: got %h want %h", ifb.dp_output_sigmoid, OSIG); end
    total++; if (ifb.dp_hidden_sigmoid !== HSIG) begin bad++; $display("FAIL lat3_dp_hsig: got %h want %h", ifb.dp_hidden_sigmoid, HSIG); end
    total++; if (ifb.dp_w_initial !== 32'h3E00_0000) begin bad++; $display("FAIL lat3_dp_winit: got %h want 3e000000", ifb.dp_w_initial); end
    wait_done(1, dm, 60);
    tick(1);
    total++; if (wr_n[1] - wm !== 4) begin bad++; $display("FAIL lat3_wr_count: got %0d want 4", wr_n[1] - wm); end
    total++; if (wr_cyc[1][wm] - rd_cyc[1][rm] !== 5) begin bad++; $display("FAIL lat3_first_wr: got %0d want 5", wr_cyc[1][wm] - rd_cyc[1][rm]); end
    for (int k = 0; k < 3; k++) begin
      total++; if (wr_cyc[1][wm+k+1] - wr_cyc[1][wm+k] !== 6) begin bad++; $display("FAIL lat3_spacing%0d: got %0d want 6", k, wr_cyc[1][wm+k+1] - wr_cyc[1][wm+k]); end
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (mem[1][k] !== 32'h3E20_0000 + 32'(k) * 32'h0001_0000) begin bad++; $display("FAIL lat3_mem%0d: got %h want %h", k, mem[1][k], 32'h3E20_0000 + 32'(k) * 32'h0001_0000); end
    end
    total++; if (done_cyc[1][dm] - rd_cyc[1][rm] !== 24) begin bad++; $display("FAIL lat3_pass_len: got %0d want 24", done_cyc[1][dm] - rd_cyc[1][rm]); end
    total++; if (dp_chg - cm !== 0) begin bad++; $display("FAIL lat3_dp_stable: got %0d changes want 0", dp_chg - cm); end
    total++; if (overlap[1] !== 0) begin bad++; $display("FAIL lat3_overlap: got %0d want 0", overlap[1]); end
  endtask

  task automatic test_single_hidden;
    int wm, rm, dm;
    init_mem(2, HALF, 32'h0);
    wm = wr_n[2]; rm = rd_n[2]; dm = done_n[2];
    pulse(2);
    total++; if ({oi_c, hi_c} !== 3'b000) begin bad++; $display("FAIL single_start_idx: got %b want 000", {oi_c, hi_c}); end
    wait_done(2, dm, 30);
    tick(1);
    total++; if (wr_n[2] - wm !== 3) begin bad++; $display("FAIL single_wr_count: got %0d want 3", wr_n[2] - wm); end
    for (int k = 0; k < 3; k++) begin
      total++; if ({wr_addr[2][wm+k], wr_oi_c[wm+k], wr_hi_c[wm+k]} !== {2'(k), 2'(k), 1'b0}) begin
        bad++; $display("FAIL single_idx%0d: got addr %0d out %0d hid %0d want %0d %0d 0", k, wr_addr[2][wm+k], wr_oi_c[wm+k], wr_hi_c[wm+k], k, k);
      end
      total++; if (mem[2][k] !== NEWW) begin bad++; $display("FAIL single_mem%0d: got %h want %h", k, mem[2][k], NEWW); end
    end
    total++; if (done_cyc[2][dm] - rd_cyc[2][rm] !== 12) begin bad++; $display("FAIL single_pass_len: got %0d want 12", done_cyc[2][dm] - rd_cyc[2][rm]); end
  endtask

  task automatic test_nan_guard;
    int wm, dm, c;
    init_mem(0, HALF, 32'h0);
    nan_addr = 2'd1;
    nan_en[0] = 1'b1;
    wm = wr_n[0]; dm = done_n[0];
    pulse(0);
    c = 0;
    while (!(ifa.w_we && ifa.w_addr == 2'd1) && c < 20) begin tick(1); c++; end
    total++; if (err_v[0] !== 1'b0) begin bad++; $display("FAIL nan_err_during_write: got %b want 0", err_v[0]); end
    tick(1);
    total++; if (err_v[0] !== GUARD) begin bad++; $display("FAIL nan_err_after_write: got %b want %b", err_v[0], GUARD); end
    wait_done(0, dm, 40);
    tick(1);
    nan_en[0] = 1'b0;
    total++; if (wr_data[0][wm+1] !== (GUARD ? HALF : QNAN)) begin bad++; $display("FAIL nan_wdata: got %h want %h", wr_data[0][wm+1], GUARD ? HALF : QNAN); end
    total++; if ({mem[0][0], mem[0][2], mem[0][3]} !== {NEWW, NEWW, NEWW}) begin bad++; $display("FAIL nan_others: got %h %h %h want %h", mem[0][0], mem[0][2], mem[0][3], NEWW); end
    total++; if (err_v[0] !== GUARD) begin bad++; $display("FAIL nan_err_sticky: got %b want %b", err_v[0], GUARD); end
    dm = done_n[0];
    pulse(0);
    total++; if (err_v[0] !== 1'b0) begin bad++; $display("FAIL nan_err_clear: got %b want 0", err_v[0]); end
    wait_done(0, dm, 40);
    tick(1);
  endtask

  task automatic test_back_to_back;
    int wm, dm;
    init_mem(0, HALF, 32'h0);
    wm = wr_n[0]; dm = done_n[0];
    pulse(0);
    wait_done(0, dm, 40);
    tick(1);
    pulse(0);
    total++; if (busy_v[0] !== 1'b1) begin bad++; $display("FAIL b2b_restart: got %b want 1", busy_v[0]); end
    wait_done(0, dm + 1, 40);
    tick(1);
    total++; if (wr_n[0] - wm !== 8) begin bad++; $display("FAIL b2b_wr_count: got %0d want 8", wr_n[0] - wm); end
    total++; if (wr_data[0][wm+6] !== 32'h3F40_0000) begin bad++; $display("FAIL b2b_second_data: got %h want 3f400000", wr_data[0][wm+6]); end
  endtask

  task automatic test_reset_mid_pass;
    int wm, dm, c;
    init_mem(0, HALF, 32'h0);
    wm = wr_n[0]; dm = done_n[0];
    pulse(0);
    c = 0;
    while (!(ifa.w_rd_en && ifa.w_addr == 2'd2) && c < 30) begin tick(1); c++; end
    total++; if (!(ifa.w_rd_en && ifa.w_addr == 2'd2)) begin bad++; $display("FAIL midrst_find_read2: got rd %b addr %0d want 1 2", ifa.w_rd_en, ifa.w_addr); end
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy_v[0], ifa.w_rd_en, ifa.w_we} !== 3'b000) begin bad++; $display("FAIL midrst_async_ctrl: got %b want 000", {busy_v[0], ifa.w_rd_en, ifa.w_we}); end
    total++; if ({ifa.w_addr, oi_a, hi_a} !== 4'h0) begin bad++; $display("FAIL midrst_async_idx: got %h want 0", {ifa.w_addr, oi_a, hi_a}); end
    total++; if (ifa.dp_w_initial !== 32'h0) begin bad++; $display("FAIL midrst_async_dp: got %h want 0", ifa.dp_w_initial); end
    tick(3);
    rst_n = 1'b1;
    tick(10);
    total++; if (wr_n[0] - wm !== 2) begin bad++; $display("FAIL midrst_wr_count: got %0d want 2", wr_n[0] - wm); end
    total++; if ({mem[0][0], mem[0][1], mem[0][2], mem[0][3]} !== {NEWW, NEWW, HALF, HALF}) begin
      bad++; $display("FAIL midrst_mem: got %h %h %h %h want %h %h %h %h", mem[0][0], mem[0][1], mem[0][2], mem[0][3], NEWW, NEWW, HALF, HALF);
    end
    total++; if (done_n[0] - dm !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", done_n[0] - dm); end
    init_mem(0, HALF, 32'h0);
    wm = wr_n[0]; dm = done_n[0];
    pulse(0);
    wait_done(0, dm, 40);
    tick(1);
    total++; if (wr_n[0] - wm !== 4) begin bad++; $display("FAIL midrst_clean_count: got %0d want 4", wr_n[0] - wm); end
    for (int k = 0; k < 4; k++) begin
      total++; if (wr_addr[0][wm+k] !== 2'(k) || mem[0][k] !== NEWW) begin bad++; $display("FAIL midrst_clean%0d: got addr %0d mem %h want %0d %h", k, wr_addr[0][wm+k], mem[0][k], k, NEWW); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_start_ignore();
    test_dp_lat3();
    test_single_hidden();
    test_nan_guard();
    test_back_to_back();
    test_reset_mid_pass();
    for (int i = 0; i < 3; i++) begin
      total++; if (overlap[i] !== 0) begin bad++; $display("FAIL rd_we_overlap%0d: got %0d want 0", i, overlap[i]); end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
